alu16_arbiter: RTL and testbench

- Round-robin controller that shares one ALU16 sign-magnitude datapath between NREQ requesters.
- Accepts one request at a time and sequences a clear/issue/capture on the ALU's control pins: ALU rst (sync, active-high), ALUop, split operand bytes.
- Returns result, overflow and error to the winning requester over a shared valid/ready response channel.
- Keeps completed-operation and overflow counters for debug.

---
 rtl/alu16_arbiter_pkg.sv | 35 +++
 rtl/alu16_arbiter_if.sv | 38 +++
 rtl/alu16_arbiter_rr_arbiter.sv | 39 +++
 rtl/alu16_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_alu16_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu16_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu16_pkg
// Brief    : Shared types and constants for the ALU16 round-robin arbiter:
//            controller state encoding, ALUop codes, index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package alu16_pkg;

    // Controller sequence: accept -> clear ALU -> issue -> capture -> respond
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ISSUE   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    // ALUop encodings understood by the ALU16 datapath
    localparam logic [2:0] OP_ILL  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_NEG  = 3'b101;
    localparam logic [2:0] OP_ABS  = 3'b110;
    localparam logic [2:0] OP_SQRT = 3'b111;

    // Requester index width; never narrower than one bit
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu16_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu16_arbiter_if
// Brief    : Request and response channels between NREQ requesters and the
//            ALU16 arbiter. master = requester side, slave = arbiter side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu16_arbiter_if #(
    parameter int NREQ = 2
) ();

    localparam int IDW = alu16_pkg::idw_of(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [3*NREQ-1:0]  req_op;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;

    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [15:0]        resp_data;
    logic               resp_ovf;
    logic               resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_ovf, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_ovf, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/alu16_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Returns the first asserted
//            request at or after ptr, wrapping modulo NREQ, as a one-hot
//            grant plus its binary index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  wire  [NREQ-1:0] req,
    input  wire  [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int w_cand;

    // Scan from the pointer outward; the first hit wins and later hits are ignored
    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = 0;
        for (int off = 0; off < NREQ; off++) begin
            w_cand = (int'(ptr) + off) % NREQ;
            if (!any && req[w_cand]) begin
                any           = 1'b1;
                grant[w_cand] = 1'b1;
                idx           = IDW'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu16_arbiter
// Brief    : Shares one ALU16 sign-magnitude datapath among NREQ requesters.
//            Accepts one request at a time, clears the ALU, issues the
//            operation, captures the result and returns it over a shared
//            valid/ready response channel. Keeps debug counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu16_arbiter
    import alu16_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  wire               clk,
    input  wire               rst_n,
    alu16_arbiter_if.slave    bus,

    output logic              alu_rst,
    output logic [2:0]        alu_op,
    output logic [7:0]        alu_cin1,
    output logic [7:0]        alu_cin1_,
    output logic [7:0]        alu_cin2,
    output logic [7:0]        alu_cin2_,
    input  wire  [15:0]       alu_cout,
    input  wire               alu_overflow,

    output logic              busy,
    output logic [CNT_W-1:0]  ops_done,
    output logic [CNT_W-1:0]  ovf_count
);

    localparam int IDW = idw_of(NREQ);

    state_t           r_state;
    state_t           w_next;

    logic [IDW-1:0]   r_rr;
    logic [IDW-1:0]   r_gid;
    logic [IDW-1:0]   w_gidx;
    logic [NREQ-1:0]  w_grant;
    logic             w_any;

    logic [2:0]       w_sel_op;
    logic [15:0]      w_sel_a;
    logic [15:0]      w_sel_b;

    logic [2:0]       r_op;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic [15:0]      r_data;
    logic             r_ovf;
    logic             r_err;

    logic [CNT_W-1:0] r_ops_done;
    logic [CNT_W-1:0] r_ovf_count;
    logic             w_resp_fire;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (r_rr),
        .grant (w_grant),
        .idx   (w_gidx),
        .any   (w_any)
    );

    // Operands of the candidate winner, used only in IDLE
    assign w_sel_op    = bus.req_op[3*w_gidx +: 3];
    assign w_sel_a     = bus.req_a[16*w_gidx +: 16];
    assign w_sel_b     = bus.req_b[16*w_gidx +: 16];
    assign w_resp_fire = (r_state == RESP) && bus.resp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: illegal opcodes skip the ALU and answer immediately
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = (w_sel_op == OP_ILL) ? RESP : CLEAR;
            CLEAR:   w_next = ISSUE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = RESP;
            RESP:    if (bus.resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded outputs; reset forces the ALU clear and blocks any accept
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = 1'b0;
        alu_rst        = 1'b0;
        busy           = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (rst_n) bus.req_ready = w_grant;
            end
            CLEAR:   alu_rst = 1'b1;
            RESP:    bus.resp_valid = 1'b1;
            default: ;
        endcase
        if (!rst_n) alu_rst = 1'b1;
    end

    // Latch the winning request; error flag and cleared result for illegal ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gid <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_err <= 1'b0;
        end else if (r_state == IDLE && w_any) begin
            r_gid <= w_gidx;
            r_op  <= w_sel_op;
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_err <= (w_sel_op == OP_ILL);
        end
    end

    // Result register: zeroed on accept, loaded from the ALU in CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else if (r_state == IDLE && w_any) begin
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else if (r_state == CAPTURE) begin
            r_data <= alu_cout;
            r_ovf  <= alu_overflow;
        end
    end

    // Round-robin pointer advances past the requester just answered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else if (w_resp_fire) begin
            r_rr <= (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
        end
    end

    // Debug counters, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops_done  <= '0;
            r_ovf_count <= '0;
        end else if (w_resp_fire) begin
            r_ops_done <= r_ops_done + 1'b1;
            if (r_ovf) r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign alu_op        = r_op;
    assign alu_cin1      = r_a[7:0];
    assign alu_cin1_     = r_a[15:8];
    assign alu_cin2      = r_b[7:0];
    assign alu_cin2_     = r_b[15:8];

    assign bus.resp_id   = r_gid;
    assign bus.resp_data = r_data;
    assign bus.resp_ovf  = r_ovf;
    assign bus.resp_err  = r_err;

    assign ops_done      = r_ops_done;
    assign ovf_count     = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_alu16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu16_arbiter
// Brief    : Scoreboard bench for alu16_arbiter with a behavioural ALU16
//            (sign-magnitude, registered result, sticky overflow cleared by
//            a synchronous active-high rst).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu16_arbiter;
    import alu16_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    alu16_arbiter_if #(.NREQ(2)) bus ();

    logic        alu_rst;
    logic [2:0]  alu_op;
    logic [7:0]  alu_cin1, alu_cin1_, alu_cin2, alu_cin2_;
    logic [15:0] alu_cout;
    logic        alu_overflow;
    logic        busy;
    logic [15:0] ops_done, ovf_count;

    logic        v0 = 1'b0, v1 = 1'b0, resp_rdy = 1'b1;
    logic [2:0]  op0 = '0, op1 = '0;
    logic [15:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;

    assign bus.req_valid  = {v1, v0};
    assign bus.req_op     = {op1, op0};
    assign bus.req_a      = {a1, a0};
    assign bus.req_b      = {b1, b0};
    assign bus.resp_ready = resp_rdy;

    alu16_arbiter #(.NREQ(2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_rst      (alu_rst),
        .alu_op       (alu_op),
        .alu_cin1     (alu_cin1),
        .alu_cin1_    (alu_cin1_),
        .alu_cin2     (alu_cin2),
        .alu_cin2_    (alu_cin2_),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .busy         (busy),
        .ops_done     (ops_done),
        .ovf_count    (ovf_count)
    );

    // ---------------- behavioural ALU16 ----------------
    function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        int va, vb, r, mag;
        logic o;
        va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
        vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
        case (op)
            3'b001:  r = va + vb;
            3'b010:  r = va - vb;
            3'b011:  r = va * vb;
            3'b101:  r = -va;
            3'b110:  r = (va < 0) ? -va : va;
            default: r = 0;
        endcase
        o   = (r > 32767) || (r < -32767);
        mag = (r < 0) ? -r : r;
        return {o, (r < 0), 15'(mag)};
    endfunction

    logic [16:0] alu_res;
    assign alu_res = alu_f(alu_op, {alu_cin1_, alu_cin1}, {alu_cin2_, alu_cin2});

    always @(posedge clk) begin
        if (alu_rst) begin
            alu_cout     <= '0;
            alu_overflow <= 1'b0;
        end else begin
            alu_cout     <= alu_res[15:0];
            alu_overflow <= alu_overflow | alu_res[16];
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        id;
        logic [15:0] data;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push_exp(input int id, input logic [15:0] d, input logic o, input logic e);
        exp_t x;
        x.id   = 1'(id);
        x.data = d;
        x.ovf  = o;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Monitor: every completed response handshake is matched against the queue
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got id %0d data 0x%0h, expected no response",
                         bus.resp_id, bus.resp_data);
            end else begin
                mon_e = sb.pop_front();
                check("resp_id",   32'(bus.resp_id),   32'(mon_e.id));
                check("resp_data", 32'(bus.resp_data), 32'(mon_e.data));
                check("resp_ovf",  32'(bus.resp_ovf),  32'(mon_e.ovf));
                check("resp_err",  32'(bus.resp_err),  32'(mon_e.err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int r, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        if (r == 0) begin v0 = v; op0 = op; a0 = a; b0 = b; end
        else        begin v1 = v; op1 = op; a1 = a; b1 = b; end
    endtask

    task automatic drop(input int r);
        if (r == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    // One request on an idle controller, checks grant, latency and ALU clear
    task automatic do_op(input int r, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] ed, input logic eo,
                         input int exp_lat);
        int lat;
        logic saw_rst;
        push_exp(r, ed, eo, (op == OP_ILL));
        @(posedge clk); #1;
        drive(r, 1'b1, op, a, b);
        @(negedge clk);
        check("req_ready_grant", 32'(bus.req_ready), (r == 0) ? 32'h1 : 32'h2);
        @(posedge clk); #1;
        drop(r);
        lat = 0;
        saw_rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (alu_rst) saw_rst = 1'b1;
            if (bus.resp_valid) begin lat = k; break; end
        end
        check("resp_latency", 32'(lat), 32'(exp_lat));
        check("alu_rst_pulse", 32'(saw_rst), (op == OP_ILL) ? 32'h0 : 32'h1);
        @(posedge clk); #1;
    endtask

    // Present a request and hold it until accepted (bounded wait)
    task automatic feed(input int r, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b);
        logic got;
        drive(r, 1'b1, op, a, b);
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin got = 1'b1; break; end
        end
        check("feed_accept", 32'(got), 32'h1);
        @(posedge clk); #1;
        drop(r);
    endtask

    task automatic wait_empty(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drain", 32'(sb.size()), 32'h0);
    endtask

    // Fairness vectors: both requesters hold four operations each
    logic [2:0]  f_op0 [4] = '{OP_ADD, OP_ADD, OP_SUB, OP_NEG};
    logic [15:0] f_a0  [4] = '{16'h0001, 16'h0002, 16'h0001, 16'h0005};
    logic [15:0] f_b0  [4] = '{16'h0001, 16'h0003, 16'h0003, 16'h0000};
    logic [15:0] f_e0  [4] = '{16'h0002, 16'h0005, 16'h8002, 16'h8005};
    logic [2:0]  f_op1 [4] = '{OP_SUB, OP_MUL, OP_ABS, OP_ADD};
    logic [15:0] f_a1  [4] = '{16'h0010, 16'h0003, 16'h8007, 16'h8002};
    logic [15:0] f_b1  [4] = '{16'h0001, 16'h0003, 16'h0000, 16'h0001};
    logic [15:0] f_e1  [4] = '{16'h000F, 16'h0009, 16'h0007, 16'h8001};

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic seen;
        rst_n = 1'b0;
        v0 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_alu_rst",   32'(alu_rst), 32'h1);
        check("rst_busy",      32'(busy), 32'h0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_ops_done",  32'(ops_done), 32'h0);
        check("rst_ovf_count", 32'(ovf_count), 32'h0);
        check("rst_alu_op",    32'(alu_op), 32'h0);
        v0 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_alu_rst", 32'(alu_rst), 32'h0);

        // Single ADD
        do_op(0, OP_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 4);
        check("ops_done_1", 32'(ops_done), 32'h1);

        // Overflow, then SUB proves the sticky flag was cleared
        do_op(0, OP_ADD, 16'h4000, 16'h4000, 16'h0000, 1'b1, 4);
        check("ovf_count_1", 32'(ovf_count), 32'h1);
        do_op(0, OP_SUB, 16'h0005, 16'h0002, 16'h0003, 1'b0, 4);

        // Illegal opcode: immediate error response, ALU untouched
        do_op(1, OP_ILL, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1);
        check("ops_done_4", 32'(ops_done), 32'h4);
        check("ovf_count_still_1", 32'(ovf_count), 32'h1);

        // Fairness: pointer is at 0, so grants alternate 0,1,0,1,...
        for (int i = 0; i < 4; i++) begin
            push_exp(0, f_e0[i], 1'b0, 1'b0);
            push_exp(1, f_e1[i], 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 4; i++) feed(0, f_op0[i], f_a0[i], f_b0[i]);
            end
            begin
                for (int j = 0; j < 4; j++) feed(1, f_op1[j], f_a1[j], f_b1[j]);
            end
        join
        wait_empty(100);
        @(negedge clk);
        check("ops_done_12", 32'(ops_done), 32'd12);

        // Backpressure: hold the response, a pending req0 must wait
        resp_rdy = 1'b0;
        push_exp(1, 16'h0004, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b1, OP_ADD, 16'h0002, 16'h0002);
        @(negedge clk);
        check("bp_grant1", 32'(bus.req_ready), 32'h2);
        @(posedge clk); #1;
        drop(1);
        drive(0, 1'b1, OP_SUB, 16'h0001, 16'h0001);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin seen = 1'b1; break; end
        end
        check("bp_resp_seen", 32'(seen), 32'h1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold", {13'h0, bus.resp_valid, bus.resp_data, bus.req_ready},
                  {13'h0, 1'b1, 16'h0004, 2'b00});
        end
        push_exp(0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        @(negedge clk);
        check("bp_no_grant_during_resp", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        check("bp_grant_after_handshake", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        drop(0);
        wait_empty(40);

        // Reset during ISSUE aborts the operation
        @(posedge clk); #1;
        drive(0, 1'b1, OP_ADD, 16'h0100, 16'h0100);
        @(negedge clk);
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        drive(1, 1'b1, OP_ADD, 16'h0001, 16'h0001);
        #1;
        check("mid_rst_outputs",
              {16'h0, bus.resp_valid, alu_rst, busy, bus.req_ready, alu_op, 8'h00},
              {16'h0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 8'h00});
        check("mid_rst_ops_done", 32'(ops_done), 32'h0);
        check("mid_rst_ovf_count", 32'(ovf_count), 32'h0);
        drop(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Pointer back at 0: req0 wins even though req1 asks at the same time
        push_exp(0, 16'h800C, 1'b0, 1'b0);
        push_exp(1, 16'h0002, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, OP_MUL, 16'h0006, 16'h8002);
        drive(1, 1'b1, OP_ADD, 16'h0001, 16'h0001);
        @(negedge clk);
        check("rr_after_reset", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        drop(0);
        feed(1, OP_ADD, 16'h0001, 16'h0001);
        wait_empty(40);
        @(negedge clk);
        check("ops_done_after_reset", 32'(ops_done), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
